// File: rtl/fetch_prefetch_unit.sv
// Instruction fetch front end: issues sequential word fetches to a req/gnt/rvalid memory
// and buffers in-order responses in a small prefetch FIFO presented to the core as {inst, pc}.
module fetch_prefetch_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW:0] DEPTH_L = (CW+1)'(DEPTH);

  typedef enum logic [1:0] {ST_RST, ST_FETCH, ST_FLUSH} state_t;

  state_t        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] discard_q, discard_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          imem_req_q, imem_req_d;
  logic          inst_valid_q, inst_valid_d;
  logic [31:0]   inst_data_q, inst_data_d;
  logic [31:0]   inst_pc_q, inst_pc_d;

  logic [31:0]   fifo_data_q [DEPTH];
  logic [31:0]   fifo_pc_q   [DEPTH];

  logic issue, rsp, drop, push, pop;
  logic [1:0] unused_pc_bits;

  assign unused_pc_bits = redirect_pc[1:0];

  always_comb begin
    issue = imem_req_q & imem_gnt;
    rsp   = imem_rvalid & (outstanding_q != '0);
    drop  = rsp & (discard_q != '0);
    push  = rsp & (discard_q == '0) & ~redirect;
    pop   = inst_valid_q & inst_ready & ~redirect;

    outstanding_d = outstanding_q + CW'(issue) - CW'(rsp);
    fetch_pc_d    = issue ? fetch_pc_q + 32'd4 : fetch_pc_q;
    resp_pc_d     = push ? resp_pc_q + 32'd4 : resp_pc_q;
    discard_d     = drop ? discard_q - CW'(1) : discard_q;
    wr_ptr_d      = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d      = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d       = count_q + CW'(push) - CW'(pop);

    // Everything still in flight after this cycle, including a same-cycle issue, is stale.
    if (redirect) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      resp_pc_d  = {redirect_pc[31:2], 2'b00};
      discard_d  = outstanding_d;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end

    case (state_q)
      ST_RST:  state_d = ST_FETCH;
      default: state_d = (discard_d != '0) ? ST_FLUSH : ST_FETCH;
    endcase

    imem_req_d = (state_d != ST_RST) &&
                 (({1'b0, count_d} + {1'b0, outstanding_d}) < DEPTH_L);

    // Head register looks ahead so a response written this cycle can be shown next cycle.
    inst_valid_d = (count_d != '0);
    inst_data_d  = inst_data_q;
    inst_pc_d    = inst_pc_q;
    if (inst_valid_d) begin
      if (push && (rd_ptr_d == wr_ptr_q)) begin
        inst_data_d = imem_rdata;
        inst_pc_d   = resp_pc_q;
      end else begin
        inst_data_d = fifo_data_q[rd_ptr_d];
        inst_pc_d   = fifo_pc_q[rd_ptr_d];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= ST_RST;
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      imem_req_q    <= 1'b0;
      inst_valid_q  <= 1'b0;
      inst_data_q   <= '0;
      inst_pc_q     <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      imem_req_q    <= imem_req_d;
      inst_valid_q  <= inst_valid_d;
      inst_data_q   <= inst_data_d;
      inst_pc_q     <= inst_pc_d;
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (push && (wr_ptr_q == PW'(gi))) begin
        fifo_data_q[gi] <= imem_rdata;
        fifo_pc_q[gi]   <= resp_pc_q;
      end
    end
  end

  assign imem_req   = imem_req_q;
  assign imem_addr  = fetch_pc_q;
  assign inst_valid = inst_valid_q;
  assign inst_data  = inst_data_q;
  assign inst_pc    = inst_pc_q;

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed bench for fetch_prefetch_unit: a per-cycle vector table plus hand-written
// sequences for flush, simultaneous events, address boundaries and mid-operation reset.
module tb_fetch_prefetch_unit;

  logic        clk;
  logic        reset;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;

  fetch_prefetch_unit dut (
    .clk         (clk),
    .reset       (reset),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst_data   (inst_data),
    .inst_pc     (inst_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        gnt;
    logic        rv;
    logic        rdy;
    logic        redir;
    logic [31:0] rpc;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_data;
  } vec_t;

  localparam int NVEC = 19;
  vec_t        vecs [NVEC];
  logic [31:0] pend [$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_issue  = 0;

  function automatic logic [31:0] mw(input logic [31:0] a);
    return 32'h8C01_0004 + a;
  endfunction

  function automatic vec_t mk(input logic r, g, rv, rd, rr, input logic [31:0] rpc,
                              input logic er, input logic [31:0] ea, input logic ev,
                              input logic [31:0] epc, input logic [31:0] ed);
    vec_t v;
    v.rst_n = r; v.gnt = g; v.rv = rv; v.rdy = rd; v.redir = rr; v.rpc = rpc;
    v.exp_req = er; v.exp_addr = ea; v.exp_valid = ev; v.exp_pc = epc; v.exp_data = ed;
    return v;
  endfunction

  // Drive one cycle; the memory answers in order from the queue of earlier issues.
  task automatic step(input logic r, g, rv, rd, rr, input logic [31:0] rpc);
    reset = r; imem_gnt = g; inst_ready = rd; redirect = rr; redirect_pc = rpc;
    imem_rvalid = 1'b0; imem_rdata = 32'h0;
    if (rv && pend.size() > 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mw(pend[0]);
      void'(pend.pop_front());
    end
    if (r && imem_req && g) begin
      pend.push_back(imem_addr);
      n_issue++;
    end
    @(posedge clk);
    #1;
    if (!r) begin
      pend.delete();
      n_issue = 0;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic er, input logic [31:0] ea,
                         input logic ev, input logic [31:0] epc, input logic [31:0] ed);
    $display("%s: req=%0b addr=%h valid=%0b pc=%h data=%h", tag, imem_req, imem_addr,
             inst_valid, inst_pc, inst_data);
    chk({tag, ".req"},   32'(imem_req),   32'(er));
    chk({tag, ".addr"},  imem_addr,       ea);
    chk({tag, ".valid"}, 32'(inst_valid), 32'(ev));
    chk({tag, ".pc"},    inst_pc,         epc);
    chk({tag, ".data"},  inst_data,       ed);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Streaming after reset, then backpressure from a fresh reset.
    vecs[0]  = mk(0,1,1,1,0,0, 0,32'h0,  0,32'h0,mw(0)-mw(0));
    vecs[1]  = mk(0,1,1,1,0,0, 0,32'h0,  0,32'h0,32'h0);
    vecs[2]  = mk(0,1,1,1,0,0, 0,32'h0,  0,32'h0,32'h0);
    vecs[3]  = mk(1,1,1,1,0,0, 1,32'h0,  0,32'h0,32'h0);
    vecs[4]  = mk(1,1,1,1,0,0, 1,32'h4,  0,32'h0,32'h0);
    vecs[5]  = mk(1,1,1,1,0,0, 1,32'h8,  1,32'h0,mw(32'h0));
    vecs[6]  = mk(1,1,1,1,0,0, 1,32'hC,  1,32'h4,mw(32'h4));
    vecs[7]  = mk(1,1,1,1,0,0, 1,32'h10, 1,32'h8,mw(32'h8));
    vecs[8]  = mk(1,1,1,1,0,0, 1,32'h14, 1,32'hC,mw(32'hC));
    vecs[9]  = mk(0,1,1,0,0,0, 0,32'h0,  0,32'h0,32'h0);
    vecs[10] = mk(1,1,1,0,0,0, 1,32'h0,  0,32'h0,32'h0);
    vecs[11] = mk(1,1,1,0,0,0, 1,32'h4,  0,32'h0,32'h0);
    vecs[12] = mk(1,1,1,0,0,0, 1,32'h8,  1,32'h0,mw(32'h0));
    vecs[13] = mk(1,1,1,0,0,0, 1,32'hC,  1,32'h0,mw(32'h0));
    vecs[14] = mk(1,1,1,0,0,0, 0,32'h10, 1,32'h0,mw(32'h0));
    vecs[15] = mk(1,1,1,0,0,0, 0,32'h10, 1,32'h0,mw(32'h0));
    vecs[16] = mk(1,1,1,0,0,0, 0,32'h10, 1,32'h0,mw(32'h0));
    vecs[17] = mk(1,1,1,1,0,0, 1,32'h10, 1,32'h4,mw(32'h4));
    vecs[18] = mk(1,1,1,0,0,0, 0,32'h14, 1,32'h4,mw(32'h4));

    reset = 1'b0; redirect = 1'b0; redirect_pc = '0; imem_gnt = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = '0; inst_ready = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      step(vecs[i].rst_n, vecs[i].gnt, vecs[i].rv, vecs[i].rdy, vecs[i].redir, vecs[i].rpc);
      chk_all($sformatf("vec%0d", i), vecs[i].exp_req, vecs[i].exp_addr,
              vecs[i].exp_valid, vecs[i].exp_pc, vecs[i].exp_data);
    end
    chk("bp.issues", 32'(n_issue), 32'd5);

    // Flush with two requests in flight.
    step(0,0,0,0,0,0);
    step(1,0,0,0,0,0);
    step(1,1,0,0,0,0);
    step(1,1,0,0,0,0);
    step(1,0,0,0,1,32'h40);
    chk_all("flush.redir", 1, 32'h40, 0, 32'h0, 32'h0);
    step(1,1,1,1,0,0);
    chk_all("flush.drop0", 1, 32'h44, 0, 32'h0, 32'h0);
    step(1,1,1,1,0,0);
    chk_all("flush.drop1", 1, 32'h48, 0, 32'h0, 32'h0);
    step(1,0,1,1,0,0);
    chk_all("flush.first", 1, 32'h48, 1, 32'h40, mw(32'h40));
    step(1,0,1,1,0,0);
    chk_all("flush.second", 1, 32'h48, 1, 32'h44, mw(32'h44));

    // Redirect, issue and response all in one cycle with two outstanding.
    step(0,0,0,0,0,0);
    step(1,0,0,0,0,0);
    step(1,1,0,0,0,0);
    step(1,1,0,0,0,0);
    step(1,1,1,0,1,32'h80);
    chk_all("simul.redir", 1, 32'h80, 0, 32'h0, 32'h0);
    step(1,1,1,1,0,0);
    chk_all("simul.drop0", 1, 32'h84, 0, 32'h0, 32'h0);
    step(1,0,1,1,0,0);
    chk_all("simul.drop1", 1, 32'h84, 0, 32'h0, 32'h0);
    step(1,0,1,0,0,0);
    chk_all("simul.first", 1, 32'h84, 1, 32'h80, mw(32'h80));

    // Boundaries: unaligned target, back-to-back redirects, address wrap, empty pops.
    step(1,0,0,0,1,32'h43);
    chk_all("bnd.align", 1, 32'h40, 0, 32'h80, mw(32'h80));
    step(1,0,0,0,1,32'hFFFF_FFFC);
    chk_all("bnd.top", 1, 32'hFFFF_FFFC, 0, 32'h80, mw(32'h80));
    step(1,1,0,0,0,0);
    chk_all("bnd.wrap", 1, 32'h0, 0, 32'h80, mw(32'h80));
    step(1,1,1,0,0,0);
    chk_all("bnd.resp_top", 1, 32'h4, 1, 32'hFFFF_FFFC, mw(32'hFFFF_FFFC));
    step(1,0,1,0,0,0);
    chk_all("bnd.hold", 1, 32'h4, 1, 32'hFFFF_FFFC, mw(32'hFFFF_FFFC));
    step(1,0,0,1,0,0);
    chk_all("bnd.resp_zero", 1, 32'h4, 1, 32'h0, mw(32'h0));
    step(1,0,0,1,0,0);
    chk_all("bnd.empty", 1, 32'h4, 0, 32'h0, mw(32'h0));
    step(1,0,0,1,0,0);
    chk_all("bnd.pop_empty", 1, 32'h4, 0, 32'h0, mw(32'h0));

    // Reset with credit exhausted (3 buffered + 1 in flight); redirect during reset is ignored.
    step(0,0,0,0,0,0);
    step(1,0,0,0,0,0);
    step(1,1,0,0,0,0);
    step(1,1,1,0,0,0);
    step(1,1,1,0,0,0);
    step(1,1,1,0,0,0);
    chk_all("mid.full", 0, 32'h10, 1, 32'h0, mw(32'h0));
    step(0,1,1,1,1,32'h100);
    chk_all("mid.reset", 0, 32'h0, 0, 32'h0, 32'h0);
    step(1,1,0,0,0,0);
    chk_all("mid.restart", 1, 32'h0, 0, 32'h0, 32'h0);
    step(1,1,0,0,0,0);
    step(1,1,0,0,0,0);
    step(1,1,0,0,0,0);
    chk_all("mid.third", 1, 32'hC, 0, 32'h0, 32'h0);
    step(1,1,0,0,0,0);
    chk_all("mid.credit", 0, 32'h10, 0, 32'h0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
